status_wr_port_arbiter: RTL

- Shares one downstream BRAM write-controller port among NUM_REQ level-held start/done write requesters.
- Requesters are the per-channel data and count writers of the status detect path; default 8 = 4 data + 4 count channels.
- Grants are round-robin, one write in flight at a time.
- A timeout watchdog releases a hung requester, and error events are counted.

---
 rtl/status_wr_port_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/status_wr_port_arbiter.sv
// status_wr_port_arbiter: round-robin share of one BRAM write port among NUM_REQ start/done requesters (req_* in, mem_wr_* out, busy/grant_id/err_* status)
module status_wr_port_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 1024,
  parameter int HOLDOFF = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_start,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*64-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    mem_wr_start,
  output logic [31:0]             mem_wr_addr,
  output logic [63:0]             mem_wr_data,
  input  logic                    mem_wr_done,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    err_timeout,
  output logic                    err_spurious,
  output logic [15:0]             err_count
);
  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, sel, idx;
  logic [2:0] mask [NUM_REQ];
  logic [31:0] wd;
  logic [NUM_REQ-1:0] elig;
  logic found, wd_hit, fin, tmo, spur;
  always_comb begin
    elig = '0;
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) elig[i] = req_start[i] && mask[i] == 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    wd_hit = TIMEOUT != 0 && wd == 32'(TIMEOUT - 1);
    fin = state == WAIT_DONE && (mem_wr_done || wd_hit);
    tmo = state == WAIT_DONE && !mem_wr_done && wd_hit;
    spur = state == IDLE && mem_wr_done;
    state_nx = state == IDLE ? (found ? WAIT_DONE : IDLE) : (fin ? IDLE : WAIT_DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  assign busy = state == WAIT_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_done <= '0;
      mem_wr_start <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      grant_id <= '0;
      err_timeout <= 1'b0;
      err_spurious <= 1'b0;
      err_count <= '0;
      ptr <= IDX_W'(NUM_REQ - 1);
      wd <= '0;
      for (int i = 0; i < NUM_REQ; i++) mask[i] <= '0;
    end else begin
      req_done <= '0;
      err_timeout <= tmo;
      err_spurious <= spur;
      if ((tmo || spur) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      for (int i = 0; i < NUM_REQ; i++) mask[i] <= mask[i] != 3'd0 ? mask[i] - 3'd1 : 3'd0;
      if (state == IDLE && found) begin
        mem_wr_start <= 1'b1;
        mem_wr_addr <= req_addr[32*sel +: 32];
        mem_wr_data <= req_data[64*sel +: 64];
        grant_id <= sel;
        wd <= '0;
      end else if (fin) begin
        mem_wr_start <= 1'b0;
        req_done[grant_id] <= 1'b1;
        ptr <= grant_id;
        mask[grant_id] <= 3'(HOLDOFF);
      end else if (state == WAIT_DONE) wd <= wd + 32'd1;
    end
  end
endmodule
